// File: rtl/mapper_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_sel_pkg
//  Description : Shared definitions for the NES mapper selector: FSM state
//                encodings, the "unsupported mapper" slot code and the
//                power-on contents of the mapper-number -> slot table.
//  Revision    : 1.0 - initial release
// ============================================================================
package mapper_sel_pkg;

    // Selector FSM encodings (values are visible on the state output)
    localparam logic [1:0] c_ST_NONE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_SWRST = 2'd3;

    // Table entry meaning "no slot implements this mapper"
    localparam logic [4:0] c_SLOT_UNSUP = 5'd31;

    // Built-in mapper -> slot assignments restored on reset
    localparam logic [7:0] c_MAP_NROM  = 8'd0;
    localparam logic [7:0] c_MAP_MMC1  = 8'd1;
    localparam logic [7:0] c_MAP_MMC3  = 8'd4;
    localparam logic [4:0] c_SLOT_NROM = 5'd0;
    localparam logic [4:0] c_SLOT_MMC1 = 5'd1;
    localparam logic [4:0] c_SLOT_MMC3 = 5'd2;

    function automatic logic [4:0] tab_default(input logic [7:0] idx);
        logic [4:0] slot;
        case (idx)
            c_MAP_NROM: slot = c_SLOT_NROM;
            c_MAP_MMC1: slot = c_SLOT_MMC1;
            c_MAP_MMC3: slot = c_SLOT_MMC3;
            default:    slot = c_SLOT_UNSUP;
        endcase
        return slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mapper_tab.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_tab
//  Description : 256 x 5 mapper-number -> slot table. Synchronous write,
//                two asynchronous read ports, asynchronous reset to the
//                built-in assignments.
//  Ports       : clk, resetn      - clock, async active-low reset
//                we/widx/wslot    - write strobe, entry index, slot value
//                ridx_a/rslot_a   - read port A (index in, slot out)
//                ridx_b/rslot_b   - read port B (index in, slot out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mapper_tab
    import mapper_sel_pkg::*;
#(
    parameter int NSLOT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       we,
    input  logic [7:0] widx,
    input  logic [4:0] wslot,
    input  logic [7:0] ridx_a,
    output logic [4:0] rslot_a,
    input  logic [7:0] ridx_b,
    output logic [4:0] rslot_b
);

    localparam logic [5:0] c_NSLOT = 6'(NSLOT);

    logic [4:0] r_tab [256];
    logic       w_wr_ok;

    // Only real slot numbers or the explicit "unsupported" code are stored;
    // anything else would later select a slot that does not exist.
    assign w_wr_ok = we && (({1'b0, wslot} < c_NSLOT) || (wslot == c_SLOT_UNSUP));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) begin
                r_tab[i] <= tab_default(8'(i));
            end
        end else if (w_wr_ok) begin
            r_tab[widx] <= wslot;
        end
    end

    assign rslot_a = r_tab[ridx_a];
    assign rslot_b = r_tab[ridx_b];

endmodule
`default_nettype wire

// File: rtl/mapper_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_sel
//  Description : Selects one of NSLOT mapper implementations from the iNES
//                header, sequences the switchover (drain the old slot, hold
//                all slots in reset, release the new one) and muxes the
//                active slot's outputs to the console side.
//  Ports       : clk, resetn                    - clock, async active-low reset
//                header, hdrvalid               - iNES header and its valid flag
//                tabwr, tabidx, tabslot         - table write port
//                prgreq, chrreq -> sprgreq/schrreq  gated requests to slots
//                slot_resetn                    - per-slot active-low reset
//                s* inputs                      - per-slot outputs, packed
//                irq..mirr outputs              - active-slot outputs
//                state, err, tmo                - FSM state, unsupported
//                                                 mapper number, sticky timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module mapper_sel
    import mapper_sel_pkg::*;
#(
    parameter int NSLOT    = 4,
    parameter int RSTCYC   = 8,
    parameter int DRAINMAX = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [127:0]          header,
    input  logic                  hdrvalid,
    input  logic                  tabwr,
    input  logic [7:0]            tabidx,
    input  logic [4:0]            tabslot,
    input  logic                  prgreq,
    input  logic                  chrreq,
    output logic                  sprgreq,
    output logic                  schrreq,
    output logic [NSLOT-1:0]      slot_resetn,
    input  logic [NSLOT-1:0]      sirq,
    input  logic [NSLOT-1:0]      sprgack,
    input  logic [NSLOT-1:0]      schrack,
    input  logic [NSLOT-1:0]      spromreq,
    input  logic [NSLOT-1:0]      scromreq,
    input  logic [8*NSLOT-1:0]    sprgrdata,
    input  logic [8*NSLOT-1:0]    schrrdata,
    input  logic [21*NSLOT-1:0]   spromaddr,
    input  logic [21*NSLOT-1:0]   scromaddr,
    input  logic [3*NSLOT-1:0]    smirr,
    output logic                  irq,
    output logic                  prgack,
    output logic                  chrack,
    output logic                  promreq,
    output logic                  cromreq,
    output logic [7:0]            prgrdata,
    output logic [7:0]            chrrdata,
    output logic [20:0]           promaddr,
    output logic [20:0]           cromaddr,
    output logic [2:0]            mirr,
    output logic [1:0]            state,
    output logic [7:0]            err,
    output logic                  tmo
);

    localparam int         c_AW       = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [7:0] c_RST_LAST = 8'(RSTCYC - 1);
    localparam logic [7:0] c_DRN_LAST = 8'(DRAINMAX - 1);
    localparam logic [5:0] c_NSLOT    = 6'(NSLOT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [c_AW-1:0] r_act;     // slot currently owning the outputs
    logic [7:0]      r_cur;     // mapper number the active slot serves
    logic [7:0]      r_cnt;     // shared SWRST / DRAIN cycle counter
    logic            r_tmo;

    logic [1:0]      w_state_nxt;
    logic [c_AW-1:0] w_act_nxt;
    logic [7:0]      w_cur_nxt;
    logic [7:0]      w_cnt_nxt;
    logic            w_tmo_nxt;

    // ------------------------------------------------------------------
    // Mapper number decode. A non-zero tail in bytes 12..15 marks an
    // old/dirty header whose upper mapper nibble cannot be trusted.
    // ------------------------------------------------------------------
    logic [7:0] w_mapper;
    logic       w_unused_hdr;

    assign w_mapper     = {(header[127:96] != 32'd0) ? 4'd0 : header[63:60], header[55:52]};
    assign w_unused_hdr = ^{header[95:64], header[59:56], header[51:0]};

    // ------------------------------------------------------------------
    // Slot table: port A looks up the live header, port B the latched one
    // ------------------------------------------------------------------
    logic [4:0] w_map_slot;
    logic [4:0] w_cur_slot;
    logic       w_cur_slot_ok;

    mapper_tab #(
        .NSLOT (NSLOT)
    ) u_tab (
        .clk     (clk),
        .resetn  (resetn),
        .we      (tabwr),
        .widx    (tabidx),
        .wslot   (tabslot),
        .ridx_a  (w_mapper),
        .rslot_a (w_map_slot),
        .ridx_b  (r_cur),
        .rslot_b (w_cur_slot)
    );

    // The entry may have been rewritten to "unsupported" after the switch
    // started; in that case act keeps its last legal value.
    assign w_cur_slot_ok = ({1'b0, w_cur_slot} < c_NSLOT);

    // ------------------------------------------------------------------
    // Active-slot mux, driven only by registered act
    // ------------------------------------------------------------------
    logic [NSLOT-1:0] w_act_oh;
    logic             w_m_irq, w_m_prgack, w_m_chrack, w_m_promreq, w_m_cromreq;
    logic [7:0]       w_m_prgrdata, w_m_chrrdata;
    logic [20:0]      w_m_promaddr, w_m_cromaddr;
    logic [2:0]       w_m_mirr;

    always_comb begin
        w_act_oh     = '0;
        w_m_irq      = 1'b0;
        w_m_prgack   = 1'b0;
        w_m_chrack   = 1'b0;
        w_m_promreq  = 1'b0;
        w_m_cromreq  = 1'b0;
        w_m_prgrdata = '0;
        w_m_chrrdata = '0;
        w_m_promaddr = '0;
        w_m_cromaddr = '0;
        w_m_mirr     = '0;
        for (int n = 0; n < NSLOT; n++) begin
            if (int'(r_act) == n) begin
                w_act_oh[n]  = 1'b1;
                w_m_irq      = sirq[n];
                w_m_prgack   = sprgack[n];
                w_m_chrack   = schrack[n];
                w_m_promreq  = spromreq[n];
                w_m_cromreq  = scromreq[n];
                w_m_prgrdata = sprgrdata[8*n +: 8];
                w_m_chrrdata = schrrdata[8*n +: 8];
                w_m_promaddr = spromaddr[21*n +: 21];
                w_m_cromaddr = scromaddr[21*n +: 21];
                w_m_mirr     = smirr[3*n +: 3];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_NONE;
            r_act   <= '0;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            c_ST_NONE: begin
                w_cnt_nxt = '0;
                if (hdrvalid) begin
                    w_cur_nxt = w_mapper;
                    if (w_map_slot != c_SLOT_UNSUP) begin
                        w_state_nxt = c_ST_SWRST;
                    end
                end
            end
            c_ST_SWRST: begin
                if (w_cur_slot_ok) begin
                    w_act_nxt = w_cur_slot[c_AW-1:0];
                end
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = '0;
                if (!hdrvalid || (w_mapper != r_cur)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // A clean drain wins over a timeout in the same cycle
                if (!w_m_promreq && !w_m_cromreq) begin
                    w_state_nxt = c_ST_NONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DRN_LAST) begin
                    w_state_nxt = c_ST_NONE;
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = c_ST_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Slot outputs are visible only while a slot is out of
    // reset (RUN/DRAIN); new requests are admitted only in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        sprgreq     = 1'b0;
        schrreq     = 1'b0;
        slot_resetn = '0;
        irq         = 1'b0;
        prgack      = 1'b0;
        chrack      = 1'b0;
        promreq     = 1'b0;
        cromreq     = 1'b0;
        prgrdata    = '0;
        chrrdata    = '0;
        promaddr    = '0;
        cromaddr    = '0;
        mirr        = '0;
        err         = '0;
        case (r_state)
            c_ST_NONE: begin
                if (hdrvalid && (w_map_slot == c_SLOT_UNSUP)) begin
                    err = w_mapper;
                end
            end
            c_ST_RUN, c_ST_DRAIN: begin
                if (r_state == c_ST_RUN) begin
                    sprgreq = prgreq;
                    schrreq = chrreq;
                end
                slot_resetn = w_act_oh;
                irq         = w_m_irq;
                prgack      = w_m_prgack;
                chrack      = w_m_chrack;
                promreq     = w_m_promreq;
                cromreq     = w_m_cromreq;
                prgrdata    = w_m_prgrdata;
                chrrdata    = w_m_chrrdata;
                promaddr    = w_m_promaddr;
                cromaddr    = w_m_cromaddr;
                mirr        = w_m_mirr;
            end
            default: ;
        endcase
    end

    assign state = r_state;
    assign tmo   = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mapper_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mapper_sel
//  Description : Self-checking bench for mapper_sel. A behavioural model of
//                the selector is stepped every clock and every output is
//                compared against it on the falling edge; directed scenarios
//                add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mapper_sel;

    localparam int NSLOT    = 4;
    localparam int RSTCYC   = 8;
    localparam int DRAINMAX = 64;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [127:0]         header = '0;
    logic                 hdrvalid = 1'b0;
    logic                 tabwr = 1'b0;
    logic [7:0]           tabidx = '0;
    logic [4:0]           tabslot = '0;
    logic                 prgreq = 1'b0, chrreq = 1'b0;
    logic                 sprgreq, schrreq;
    logic [NSLOT-1:0]     slot_resetn;
    logic [NSLOT-1:0]     sirq = '0, sprgack = '0, schrack = '0, spromreq = '0, scromreq = '0;
    logic [8*NSLOT-1:0]   sprgrdata = '0, schrrdata = '0;
    logic [21*NSLOT-1:0]  spromaddr = '0, scromaddr = '0;
    logic [3*NSLOT-1:0]   smirr = '0;
    logic                 irq, prgack, chrack, promreq, cromreq;
    logic [7:0]           prgrdata, chrrdata;
    logic [20:0]          promaddr, cromaddr;
    logic [2:0]           mirr;
    logic [1:0]           state;
    logic [7:0]           err;
    logic                 tmo;

    mapper_sel #(
        .NSLOT(NSLOT), .RSTCYC(RSTCYC), .DRAINMAX(DRAINMAX)
    ) dut (
        .clk(clk), .resetn(resetn), .header(header), .hdrvalid(hdrvalid),
        .tabwr(tabwr), .tabidx(tabidx), .tabslot(tabslot),
        .prgreq(prgreq), .chrreq(chrreq), .sprgreq(sprgreq), .schrreq(schrreq),
        .slot_resetn(slot_resetn),
        .sirq(sirq), .sprgack(sprgack), .schrack(schrack),
        .spromreq(spromreq), .scromreq(scromreq),
        .sprgrdata(sprgrdata), .schrrdata(schrrdata),
        .spromaddr(spromaddr), .scromaddr(scromaddr), .smirr(smirr),
        .irq(irq), .prgack(prgack), .chrack(chrack), .promreq(promreq), .cromreq(cromreq),
        .prgrdata(prgrdata), .chrrdata(chrrdata), .promaddr(promaddr), .cromaddr(cromaddr),
        .mirr(mirr), .state(state), .err(err), .tmo(tmo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 slot reset
    // ------------------------------------------------------------------
    int m_phase, m_slot, m_cur, m_rst_left, m_drain_cnt;
    bit m_tmo;
    int m_tab [256];

    function automatic int hdr_mapper();
        int hi;
        hi = (header[127:96] != 32'd0) ? 0 : int'(header[63:60]);
        return hi * 16 + int'(header[55:52]);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_slot = 0; m_cur = 0; m_rst_left = 0; m_drain_cnt = 0; m_tmo = 0;
        for (int i = 0; i < 256; i++) m_tab[i] = 31;
        m_tab[0] = 0; m_tab[1] = 1; m_tab[4] = 2;
    endtask

    task automatic model_step();
        int mp;
        mp = hdr_mapper();
        case (m_phase)
            0: if (hdrvalid) begin
                   m_cur = mp;
                   if (m_tab[mp] != 31) begin m_phase = 3; m_rst_left = RSTCYC; end
               end
            3: begin
                   if (m_tab[m_cur] < NSLOT) m_slot = m_tab[m_cur];
                   m_rst_left--;
                   if (m_rst_left == 0) m_phase = 1;
               end
            1: if (!hdrvalid || mp != m_cur) begin m_phase = 2; m_drain_cnt = 0; end
            default: begin
                   m_drain_cnt++;
                   if (!(spromreq[m_slot] || scromreq[m_slot])) m_phase = 0;
                   else if (m_drain_cnt == DRAINMAX) begin m_phase = 0; m_tmo = 1; end
               end
        endcase
        if (tabwr && (int'(tabslot) < NSLOT || tabslot == 5'd31)) m_tab[tabidx] = int'(tabslot);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_step();
        end
    end

    task automatic compare_all();
        int s; bit live; bit run; int mp;
        s = m_slot; live = (m_phase == 1) || (m_phase == 2); run = (m_phase == 1);
        mp = hdr_mapper();
        chk("state",       32'(state),       32'(m_phase));
        chk("slot_resetn", 32'(slot_resetn), live ? (32'd1 << s) : 32'd0);
        chk("sprgreq",     32'(sprgreq),     run ? 32'(prgreq) : 32'd0);
        chk("schrreq",     32'(schrreq),     run ? 32'(chrreq) : 32'd0);
        chk("irq",         32'(irq),         live ? 32'(sirq[s]) : 32'd0);
        chk("prgack",      32'(prgack),      live ? 32'(sprgack[s]) : 32'd0);
        chk("chrack",      32'(chrack),      live ? 32'(schrack[s]) : 32'd0);
        chk("promreq",     32'(promreq),     live ? 32'(spromreq[s]) : 32'd0);
        chk("cromreq",     32'(cromreq),     live ? 32'(scromreq[s]) : 32'd0);
        chk("prgrdata",    32'(prgrdata),    live ? 32'(sprgrdata[s*8 +: 8]) : 32'd0);
        chk("chrrdata",    32'(chrrdata),    live ? 32'(schrrdata[s*8 +: 8]) : 32'd0);
        chk("promaddr",    32'(promaddr),    live ? 32'(spromaddr[s*21 +: 21]) : 32'd0);
        chk("cromaddr",    32'(cromaddr),    live ? 32'(scromaddr[s*21 +: 21]) : 32'd0);
        chk("mirr",        32'(mirr),        live ? 32'(smirr[s*3 +: 3]) : 32'd0);
        chk("err",         32'(err),         (m_phase == 0 && hdrvalid && m_tab[mp] == 31) ? 32'(mp) : 32'd0);
        chk("tmo",         32'(tmo),         32'(m_tmo));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [NSLOT-1:0] req_mask  = '1;   // bits of spromreq/scromreq held by the test
    logic [NSLOT-1:0] req_force = '0;   // value of the held spromreq bits

    function automatic logic [127:0] mk_hdr(input int m, input bit junk);
        logic [127:0] h;
        h = '0;
        h[63:60] = 4'(m >> 4);
        h[55:52] = 4'(m);
        h[7:0]   = 8'hA5;
        h[90]    = 1'b1;
        if (junk) h[110] = 1'b1;
        return h;
    endfunction

    task automatic apply_reqs();
        spromreq = (NSLOT'($urandom) & ~req_mask) | (req_force & req_mask);
        scromreq = NSLOT'($urandom) & ~req_mask;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            sirq      = NSLOT'($urandom);
            sprgack   = NSLOT'($urandom);
            schrack   = NSLOT'($urandom);
            sprgrdata = ($urandom);
            schrrdata = ($urandom);
            spromaddr = 84'({$urandom, $urandom, $urandom});
            scromaddr = 84'({$urandom, $urandom, $urandom});
            smirr     = 12'($urandom);
            apply_reqs();
        end
    endtask

    // Wait (bounded) for the DUT to enter st, then count cycles spent there
    task automatic count_state(input logic [1:0] st, input int bound, output int n, output bit saw_req);
        int w;
        w = 0; n = 0; saw_req = 0;
        @(negedge clk);
        while (state !== st && w < bound) begin w++; @(negedge clk); end
        if (state !== st) begin
            n_chk++; n_fail++;
            $display("FAIL wait_state: state %0d never reached, got %0d", st, state);
            return;
        end
        while (state === st && n < bound) begin
            n++;
            saw_req |= (sprgreq | schrreq);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int  n;
        bit  sr;
        int  w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_slot_resetn", 32'(slot_resetn), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        @(posedge clk); #2; resetn = 1'b1;
        tick(2);

        // Mapper 1: SWRST for RSTCYC cycles, then slot 1 runs
        header = mk_hdr(1, 0); hdrvalid = 1'b1;
        count_state(2'd3, 50, n, sr);
        chk("m1_swrst_len", 32'(n), 32'd8);
        chk("m1_state_run", 32'(state), 32'd1);
        chk("m1_slot_resetn", 32'(slot_resetn), 32'b0010);
        req_mask = '0; prgreq = 1'b1; chrreq = 1'b1;
        tick(10);
        sprgack = 4'b0010; #1;
        chk("m1_prgack_hi", 32'(prgack), 32'd1);
        sprgack = 4'b1101; #1;
        chk("m1_prgack_lo", 32'(prgack), 32'd0);
        req_mask = '1;
        tick(1);

        // Mapper 1 -> 4 with slot 1 still fetching for 5 cycles
        header = mk_hdr(4, 0); req_force = 4'b0010; apply_reqs();
        fork
            count_state(2'd2, 50, n, sr);
            begin tick(5); req_force = '0; apply_reqs(); end
        join
        chk("m14_drain_len", 32'(n), 32'd5);
        chk("m14_no_req_in_drain", 32'(sr), 32'd0);
        count_state(2'd3, 50, n, sr);
        chk("m14_swrst_len", 32'(n), 32'd8);
        chk("m14_slot_resetn", 32'(slot_resetn), 32'b0100);
        chk("m14_tmo_clear", 32'(tmo), 32'd0);

        // Mapper 4 -> 1 with slot 2 stuck requesting: drain timeout
        header = mk_hdr(1, 0); req_force = 4'b0100; apply_reqs();
        count_state(2'd2, 200, n, sr);
        chk("tmo_drain_len", 32'(n), 32'd64);
        chk("tmo_set", 32'(tmo), 32'd1);
        req_force = '0; apply_reqs();
        count_state(2'd3, 50, n, sr);
        chk("tmo_slot_resetn", 32'(slot_resetn), 32'b0010);
        chk("tmo_sticky", 32'(tmo), 32'd1);

        // Unsupported mapper 7, then install it in slot 3
        header = mk_hdr(7, 0);
        tick(5);
        chk("m7_state", 32'(state), 32'd0);
        chk("m7_err", 32'(err), 32'd7);
        chk("m7_slot_resetn", 32'(slot_resetn), 32'd0);
        tabwr = 1'b1; tabidx = 8'd7; tabslot = 5'd3;
        tick(1);
        tabwr = 1'b0;
        count_state(2'd3, 50, n, sr);
        chk("m7_swrst_len", 32'(n), 32'd8);
        chk("m7_slot_resetn_run", 32'(slot_resetn), 32'b1000);

        // Reset pulse in the middle of a switchover
        header = mk_hdr(4, 0);
        w = 0;
        while (state !== 2'd3 && w < 20) begin tick(1); w++; end
        chk("rst_mid_reached_swrst", 32'(state), 32'd3);
        tick(2);
        sirq = '1; sprgack = '1; spromreq = '1; sprgrdata = '1;
        resetn = 1'b0; #1;
        chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_slot_resetn", 32'(slot_resetn), 32'd0);
        chk("rst_mid_tmo", 32'(tmo), 32'd0);
        chk("rst_mid_outs", 32'({irq, prgack, promreq, prgrdata}), 32'd0);
        tick(2);
        resetn = 1'b1; header = mk_hdr(7, 0);
        tick(3);
        chk("rst_tab_restored_state", 32'(state), 32'd0);
        chk("rst_tab_restored_err", 32'(err), 32'd7);

        // Out-of-range slot write is dropped
        tabwr = 1'b1; tabidx = 8'd7; tabslot = 5'd9;
        tick(1);
        tabwr = 1'b0;
        tick(3);
        chk("slot9_ignored_state", 32'(state), 32'd0);
        chk("slot9_ignored_err", 32'(err), 32'd7);

        // Dirty header tail masks the upper nibble: 0x14 decodes as 4
        header = mk_hdr(8'h14, 1);
        count_state(2'd3, 50, n, sr);
        chk("junk_swrst_len", 32'(n), 32'd8);
        chk("junk_slot_resetn", 32'(slot_resetn), 32'b0100);

        // Rewriting the active entry waits for the next switchover
        tabwr = 1'b1; tabidx = 8'd4; tabslot = 5'd1;
        tick(1);
        tabidx = 8'd0; tabslot = 5'd31;
        tick(1);
        tabwr = 1'b0;
        tick(3);
        chk("live_rewrite_keeps_act", 32'(slot_resetn), 32'b0100);

        // Mapper 0 made unsupported reports err 0
        header = mk_hdr(0, 0);
        tick(6);
        chk("m0_unsup_state", 32'(state), 32'd0);
        chk("m0_unsup_err", 32'(err), 32'd0);

        // Next switchover picks up the rewritten entry for mapper 4
        header = mk_hdr(4, 0);
        count_state(2'd3, 50, n, sr);
        chk("rewrite_swrst_len", 32'(n), 32'd8);
        chk("rewrite_slot_resetn", 32'(slot_resetn), 32'b0010);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mapper_sel.md
MAPPER_SEL -- requirements
Module: mapper_sel

Interface
REQ-001 SHALL have parameter NSLOT, default 4, meaning number of mapper slots (2..16).
REQ-002 SHALL have parameter RSTCYC, default 8, meaning slot-reset hold cycles on switchover (1..255).
REQ-003 SHALL have parameter DRAINMAX, default 64, meaning drain timeout in cycles (1..255).
REQ-004 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: header  in  128  iNES header; hdrvalid  in  1  header stable/valid.
REQ-006 SHALL have ports: tabwr  in  1  table write strobe; tabidx  in  8  mapper number; tabslot  in  5  slot index, 31 = unsupported.
REQ-007 SHALL have ports: prgreq, chrreq  in  1 each  CPU/PPU requests; sprgreq, schrreq  out  1 each  gated requests broadcast to slots.
REQ-008 SHALL have ports: slot_resetn  out  NSLOT  per-slot active-low reset.
REQ-009 SHALL have ports: sirq, sprgack, schrack, spromreq, scromreq  in  NSLOT each; sprgrdata, schrrdata  in  8*NSLOT; spromaddr, scromaddr  in  21*NSLOT; smirr  in  3*NSLOT (slot n occupies bits [w*n +: w]).
REQ-010 SHALL have ports: irq, prgack, chrack, promreq, cromreq  out  1; prgrdata, chrrdata  out  8; promaddr, cromaddr  out  21; mirr  out  3  active-slot outputs.
REQ-011 SHALL have ports: state  out  2  FSM state; err  out  8  unsupported mapper number, else 0; tmo  out  1  sticky drain timeout.

Function
REQ-012 SHALL compute mapper = {header[127:96]!=0 ? 4'd0 : header[63:60], header[55:52]} combinationally.
REQ-013 SHALL hold a 256-entry table of 5-bit slot indices; reset contents: entry 0->0, 1->1, 4->2, all others 31.
REQ-014 SHALL write table[tabidx] <= tabslot on tabwr; writes with tabslot >= NSLOT and != 31 SHALL be ignored.
REQ-015 SHALL run FSM states NONE(0), RUN(1), DRAIN(2), SWRST(3).
REQ-016 SHALL, in NONE, force every slot_resetn low, all outputs 0, and, when hdrvalid=1, latch cur=mapper and go to SWRST if table[mapper]!=31, else stay with err=mapper.
REQ-017 SHALL, in RUN, pass sprgreq=prgreq, schrreq=chrreq, mux all slot outputs from act; on hdrvalid=0 or mapper!=cur go to DRAIN.
REQ-018 SHALL, in DRAIN, force sprgreq=schrreq=0, keep outputs muxed from act, and go to NONE when spromreq[act]=0 and scromreq[act]=0, or when the drain counter reaches DRAINMAX (then set tmo=1).
REQ-019 SHALL, in SWRST, hold slot_resetn[n]=0 for all n, load act=table[cur], count RSTCYC cycles, then go to RUN releasing only slot_resetn[act].
REQ-020 SHALL keep slot_resetn[n]=0 for every n != act at all times.
REQ-021 SHALL register state, act, cur, counters and tmo; output muxing SHALL be combinational from registered act (zero latency).
REQ-022 SHALL give a table write to the entry of cur while in RUN effect only on the next switchover.
REQ-023 SHALL clear tmo only by reset.
REQ-024 SHALL make err nonzero only in NONE with hdrvalid=1 and an unsupported mapper; a mapper 0 that is unsupported SHALL report err=0 with state=NONE.

Reset
REQ-025 SHALL, on resetn=0, immediately set state=NONE, act=0, cur=0, counters=0, tmo=0, slot_resetn all 0, table to REQ-013 contents.
REQ-026 SHALL, on reset asserted mid-DRAIN or mid-SWRST, abandon the sequence without completing drain.

Structure
REQ-027 SHALL place FSM state encodings, the unsupported code 31 and the default table entries in the shared nes package.
REQ-028 SHALL implement the table as one sub-module mapper_tab (256x5, sync write, async read).

Verification
REQ-029 SHALL cover header mapper 1, hdrvalid=1 -> SWRST 8 cycles, RUN, act=1, slot_resetn=0010, prgack follows sprgack[1].
REQ-030 SHALL cover mapper 1->4 with spromreq[1]=1 for 5 cycles -> DRAIN 5 cycles, sprgreq=0 throughout, then NONE, SWRST, act=2.
REQ-031 SHALL cover spromreq[act] stuck at 1 -> DRAIN exits after 64 cycles, tmo=1 sticky.
REQ-032 SHALL cover header mapper 7 -> state NONE, err=7, slot_resetn=0000; tabwr idx 7 slot 3 -> SWRST then act=3.
REQ-033 SHALL cover resetn pulse during SWRST -> state=NONE, all outputs 0 that same cycle, table restored.
REQ-034 SHALL cover tabwr slot 9 with NSLOT=4 -> ignored, table entry unchanged.
